// File: rtl/note_key_tracker_if.sv
// rtl/note_key_tracker_if.sv - note inputs, renderer handshake and key outputs of the note tracker
// master = tracker side, slave = stimulus/renderer side.
interface note_key_tracker_if;
  logic [6:0] iNotes;
  logic       iDone;
  logic [2:0] oKey;
  logic       oPlot;
  logic       oBusy;

  modport master (input iNotes, input iDone, output oKey, output oPlot, output oBusy);
  modport slave  (output iNotes, output iDone, input oKey, input oPlot, input oBusy);
endinterface

// File: rtl/note_key_tracker.sv
// rtl/note_key_tracker.sv - synchronise, debounce and priority-encode notes; paced redraw requests
// Optional NOTE_KEY_HOLD_EN: ignore the all-released code so the last note stays highlighted.
module note_key_tracker #(
  parameter int NUM_KEYS        = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DEB_W           = 16,
  parameter int START_TIMEOUT   = 4
) (
  input  logic               iClock,
  input  logic               iReset,
  note_key_tracker_if.master bus
);

  localparam int TMO_W = $clog2(START_TIMEOUT + 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW, WAIT_HIGH} state_t;

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [DEB_W-1:0]    cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [2:0]          key_q, key_d;
  logic [2:0]          last_q, last_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [2:0]          target;
  logic                send_ok;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      key_q    <= '0;
      last_q   <= '0;
      tmo_q    <= '0;
    end else begin
      s1_q     <= bus.iNotes;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      key_q    <= key_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
    end
  end

  // Whole-vector debounce: any bit change restarts the stability count.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != DEB_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == DEB_LAST) stable_d = cand_q;
    end
  end

  always_comb begin
    target = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (stable_q[i]) target = 3'(i + 1);
    end
  end

`ifdef NOTE_KEY_HOLD_EN
  assign send_ok = (target != 3'd0) && (target != last_q);
`else
  assign send_ok = (target != last_q);
`endif

  // lastSent only advances once the renderer has actually drawn the frame.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (send_ok && bus.iDone) begin
          state_d = REQ;
          key_d   = target;
        end
      end
      REQ: begin
        state_d = WAIT_LOW;
        tmo_d   = '0;
      end
      WAIT_LOW: begin
        if (!bus.iDone) begin
          state_d = WAIT_HIGH;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (bus.iDone) begin
          last_d  = key_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oKey  = key_q;
  assign bus.oPlot = (state_q == REQ);
  assign bus.oBusy = (state_q != IDLE);

endmodule

// File: tb/tb_note_key_tracker.sv
// tb/tb_note_key_tracker.sv - directed bench with a window-rule reference model for note_key_tracker
// Build with NOTE_KEY_HOLD_EN to check the hold variant.
module tb_note_key_tracker;
  localparam int DEB = 4;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  note_key_tracker_if bus();

  note_key_tracker #(.NUM_KEYS(7), .DEBOUNCE_CYCLES(DEB), .DEB_W(4), .START_TIMEOUT(TMO)) dut (
    .iClock(clk),
    .iReset(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_g = 0;
  int plot_cnt = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Renderer: drops iDone one cycle after a request for rend_low cycles, unless stuck idle.
  bit rend_stuck = 0;
  int rend_low = 10;
  bit pend = 0;
  int low_left = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pend = 0;
      low_left = 0;
      bus.iDone = 1'b1;
    end else if (low_left > 0) begin
      low_left--;
      if (low_left == 0) bus.iDone = 1'b1;
    end else if (pend) begin
      pend = 0;
      bus.iDone = 1'b0;
      low_left = rend_low;
    end else if (bus.oPlot && !rend_stuck) begin
      pend = 1;
    end
  end

  // Reference: a raw vector reaches stable once its samples at edges k-2-DEB..k-2 all agree.
  logic [6:0] hist [0:DEB+2];
  logic [6:0] m_stable = '0;
  logic [2:0] m_key = '0;
  logic [2:0] m_last = '0;
  logic [2:0] m_tgt;
  int m_phase = 0;
  int m_tmo = 0;
  bit m_want, m_agree;

  function automatic logic [2:0] lowest_note(input logic [6:0] v);
    logic [6:0] t;
    int n;
    if (v == 7'd0) return 3'd0;
    t = v;
    n = 1;
    while (!t[0]) begin
      t = t >> 1;
      n++;
    end
    return 3'(n);
  endfunction

  always @(posedge clk) begin
    cyc_g++;
    if (rst) begin
      for (int j = 0; j <= DEB + 2; j++) hist[j] = '0;
      m_stable = '0;
      m_key = '0;
      m_last = '0;
      m_phase = 0;
      m_tmo = 0;
    end else begin
      m_tgt = lowest_note(m_stable);
`ifdef NOTE_KEY_HOLD_EN
      m_want = (m_tgt != 3'd0) && (m_tgt != m_last);
`else
      m_want = (m_tgt != m_last);
`endif
      if (m_phase == 0) begin
        if (m_want && bus.iDone) begin
          m_phase = 1;
          m_key = m_tgt;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_tmo = 0;
      end else if (m_phase == 2) begin
        if (!bus.iDone) m_phase = 3;
        else if (m_tmo == TMO - 1) m_phase = 0;
        else m_tmo++;
      end else begin
        if (bus.iDone) begin
          m_last = m_key;
          m_phase = 0;
        end
      end
      for (int j = DEB + 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = bus.iNotes;
      m_agree = 1;
      for (int j = 3; j <= DEB + 2; j++) if (hist[j] != hist[2]) m_agree = 0;
      if (m_agree) m_stable = hist[2];
    end
  end

  always @(negedge clk) begin
    if (bus.oPlot === 1'b1) plot_cnt++;
    if (cmp_en) begin
      check("model_key", int'(bus.oKey), int'(m_key));
      check("model_plot", int'(bus.oPlot), (m_phase == 1) ? 1 : 0);
      check("model_busy", int'(bus.oBusy), (m_phase != 0) ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_plot(input string name, input int max, output int cyc);
    bit ok;
    ok = 0;
    cyc = 0;
    while (cyc < max) begin
      @(negedge clk);
      if (bus.oPlot === 1'b1) begin
        ok = 1;
        break;
      end
      cyc++;
    end
    if (!ok) check(name, 0, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input string name);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 20 && n < 400) begin
      @(negedge clk);
      if (bus.oBusy === 1'b0) quiet++;
      else quiet = 0;
      n++;
    end
    if (quiet < 20) check(name, 0, 1);
    @(posedge clk);
    #2;
  endtask

  int c, p0, p1, snap;

  initial begin
    bus.iNotes = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    check("reset_key", int'(bus.oKey), 0);
    check("reset_plot", int'(bus.oPlot), 0);
    check("reset_busy", int'(bus.oBusy), 0);
    tick(20);
    check("idle_no_plot", plot_cnt, 0);

    // Single press: request in cycle DEB+4, held until the renderer finishes.
    bus.iNotes = 7'b0000100;
    wait_plot("plot3_timeout", 40, c);
    check("latency", c, 8);
    check("key3", int'(bus.oKey), 3);
    snap = plot_cnt;
    settle("settle3");
    check("single_plot", plot_cnt - snap, 0);
    check("key3_held", int'(bus.oKey), 3);

    // Lowest note wins; short glitch must not reach the encoder.
    bus.iNotes = 7'b1010000;
    wait_plot("plot5_timeout", 40, c);
    check("key5", int'(bus.oKey), 5);
    settle("settle5");
    snap = plot_cnt;
    bus.iNotes = 7'b1010001;
    tick(2);
    bus.iNotes = 7'b1010000;
    settle("settle_glitch");
    check("glitch_no_plot", plot_cnt - snap, 0);
    check("glitch_key5", int'(bus.oKey), 5);

    // Changes while busy coalesce into one follow-up request.
    rend_low = 40;
    bus.iNotes = 7'b0000100;
    wait_plot("plot_c3_timeout", 40, c);
    snap = plot_cnt;
    tick(2);
    bus.iNotes = 7'b0100000;
    tick(10);
    bus.iNotes = 7'b0000010;
    settle("settle_coalesce");
    check("coalesce_plots", plot_cnt - snap, 1);
    check("coalesce_key2", int'(bus.oKey), 2);

    // Renderer never starts: retry period TMO+2 with a constant key.
    rend_low = 10;
    rend_stuck = 1;
    bus.iNotes = 7'b1000000;
    wait_plot("retry0_timeout", 40, c);
    p0 = cyc_g;
    for (int k = 0; k < 3; k++) begin
      wait_plot("retry_timeout", 20, c);
      p1 = cyc_g;
      check("retry_period", p1 - p0, TMO + 2);
      check("retry_key7", int'(bus.oKey), 7);
      p0 = p1;
    end
    rend_stuck = 0;
    wait_plot("plot7_timeout", 20, c);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("midframe_reset_key", int'(bus.oKey), 0);
    check("midframe_reset_plot", int'(bus.oPlot), 0);
    check("midframe_reset_busy", int'(bus.oBusy), 0);
    settle("settle_after_reset");

    // Releasing all notes.
    bus.iNotes = 7'b0001000;
    wait_plot("plot4_timeout", 40, c);
    check("key4", int'(bus.oKey), 4);
    settle("settle4");
    snap = plot_cnt;
    bus.iNotes = 7'b0000000;
    tick(12);
    settle("settle_release");
`ifdef NOTE_KEY_HOLD_EN
    check("release_plots", plot_cnt - snap, 0);
    check("release_key", int'(bus.oKey), 4);
`else
    check("release_plots", plot_cnt - snap, 1);
    check("release_key", int'(bus.oKey), 0);
`endif

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_key_tracker.md
Name: note_key_tracker

Overview:
- Upstream front end for the keyboard renderer. Takes the seven raw note inputs and synchronises and debounces them.
- Priority-encodes the pressed note into a 3-bit key code (0 = none, 1..7 = note) and issues one-cycle redraw requests.
- Requests are paced by the renderer's done flag, so each frame is drawn with one stable code and intermediate changes coalesce.

Parameters:
- NUM_KEYS, 7, number of note inputs. Fixed at 7 because the key code is 3 bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a new input vector is committed. Minimum 1.
- DEB_W, 16, debounce counter width. Must satisfy 2^DEB_W > DEBOUNCE_CYCLES.
- START_TIMEOUT, 4, cycles to wait for iDone to fall after a request before retrying.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iNotes  in  7  raw note inputs, active-high, asynchronous to iClock; bit n = note n+1.
- iDone   in  1  renderer done flag. High = idle, low = frame being drawn.
- oKey    out 3  registered key code to the renderer's key input. 0 = none.
- oPlot   out 1  one-cycle redraw request to the renderer's plot input.
- oBusy   out 1  high from the request cycle until the renderer reports done again.

Behaviour:
- Reset (iReset high at a clock edge):
  - sync flops, candidate, stable vector, counter, oKey and lastSent all 0.
  - FSM goes to IDLE; oPlot=0, oBusy=0.
  - Reset wins over every other event, including mid-frame. An outstanding request is abandoned.
- Synchroniser: two flops per bit. s2 is the synchronised vector.
- Debounce (whole vector):
  - If s2 != candidate: candidate <= s2 and counter <= 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - When counter == DEBOUNCE_CYCLES-1 and s2 == candidate: stable <= candidate.
  - Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Encode: target = index+1 of the lowest set bit of stable, or 0 if stable == 0. Simultaneous presses resolve to the lowest note.
- FSM states: IDLE, REQ, WAIT_LOW, WAIT_HIGH.
  - IDLE: if target != lastSent and iDone=1, go to REQ and register oKey <= target on the same edge.
  - REQ: oPlot=1 for exactly this cycle, then go to WAIT_LOW with the timeout counter cleared.
  - WAIT_LOW:
    - If iDone=0, go to WAIT_HIGH.
    - Else if the timeout counter reaches START_TIMEOUT-1, go to IDLE with lastSent unchanged (automatic retry).
  - WAIT_HIGH: when iDone=1, lastSent <= oKey and go to IDLE.
- oBusy = 1 in REQ, WAIT_LOW and WAIT_HIGH.
- oKey is held constant outside the IDLE->REQ edge. The renderer latches it while leaving its idle state.
- Target changes while busy are not lost. After return to IDLE, the latest target is compared against lastSent and at most one new request is issued. Intermediate values are dropped.
- Latency: with iDone=1, a clean iNotes edge at cycle 0 produces oPlot high in cycle DEBOUNCE_CYCLES+4 (2 sync + 1 candidate load + DEBOUNCE_CYCLES + 1 FSM).
- A return to the same code (e.g. 3 -> 0 -> 3 within one frame) only issues a request if the value differs from lastSent when the FSM is back in IDLE.

Optional Feature:
- Macro: NOTE_KEY_HOLD_EN.
- Defined: target 0 is ignored in IDLE. Releasing all notes leaves the last note highlighted and no request is issued for 0. oKey stays 0 only until the first press after reset.
- Undefined: release produces target 0 and a redraw with oKey=0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and START_TIMEOUT=4.
- Reset, then a renderer model holding iDone=1 -> oKey=0, oPlot=0, oBusy=0; no request while iNotes=0.
- iNotes=7'b0000100 held; renderer drops iDone 1 cycle after oPlot for 10 cycles -> oPlot one pulse in cycle 8, oKey=3, oBusy high until iDone returns; no second pulse.
- iNotes=7'b1010000 -> oKey=5 (lowest note wins). Then a 2-cycle pulse adding bit0 -> no change, no oPlot.
- During WAIT_HIGH, iNotes goes 3 -> 6 -> 2 (each stable >4 cycles) -> exactly one further request after iDone rises, with oKey=2.
- Renderer never drops iDone -> oPlot repeats every START_TIMEOUT+2 cycles with a constant oKey. Assert iReset mid-WAIT_HIGH -> all outputs 0 the next cycle.
- Release all notes after oKey=4 -> without NOTE_KEY_HOLD_EN, request with oKey=0; with it defined, no request and oKey stays 4.
